// File: rtl/priority_line_encoder.sv
// Sequential 8-to-3 priority encoder: sticky pending capture of event lines,
// highest-priority pending line presented as {A,B,C} under Valid/Ready.
//
// state   | meaning
// IDLE    | nothing presented, Valid=0; loads a code once pending is non-zero
// PRESENT | {A,B,C} holds a valid code, Valid=1; reloads or idles on Ready
module priority_line_encoder #(
  parameter int LINES  = 8,
  parameter int CODE_W = 3
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Enable,
  input  logic [LINES-1:0] F,
  input  logic             Ready,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             Valid,
  output logic [LINES-1:0] Pending,
  output logic             Overrun
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [LINES-1:0]    pending_q;
  logic [LINES-1:0]    pending_d;
  logic [LINES-1:0]    clr;
  logic [LINES-1:0]    pend_masked;
  logic                overrun_q;
  logic                overrun_d;
  logic                accept;

  // Line F[7-k] maps to code k, so the highest set index yields the smallest code.
  function automatic logic [CODE_W-1:0] encode(input logic [LINES-1:0] p);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < LINES; i++) begin
      if (p[i]) code = CODE_W'(LINES - 1 - i);
    end
    return code;
  endfunction

  always_comb begin
    accept      = (state_q == PRESENT) && Ready;
    clr         = '0;
    if (accept) clr = LINES'(1) << (CODE_W'(LINES - 1) - code_q);
    pend_masked = pending_q & ~clr;
    pending_d   = pend_masked;
    overrun_d   = overrun_q;
    if (Enable) begin
      pending_d = pend_masked | F;
      overrun_d = overrun_q | (|(F & pend_masked));
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Reload decisions use only lines pending before this edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      code_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            code_q  <= encode(pending_q);
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (Ready) begin
            if (|pend_masked) begin
              code_q  <= encode(pend_masked);
              state_q <= PRESENT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A       = code_q[2];
  assign B       = code_q[1];
  assign C       = code_q[0];
  assign Valid   = (state_q == PRESENT);
  assign Pending = pending_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_priority_line_encoder.sv
// Self-checking bench for priority_line_encoder: per-scenario tasks with a
// queue of expected codes popped at each accepted transfer.
module tb_priority_line_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] f;
  logic       rdy;
  logic       a, b, c;
  logic       valid;
  logic [7:0] pend;
  logic       ovr;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_code;

  priority_line_encoder dut (
    .Clock   (clk),
    .Resetn  (rst_n),
    .Enable  (en),
    .F       (f),
    .Ready   (rdy),
    .A       (a),
    .B       (b),
    .C       (c),
    .Valid   (valid),
    .Pending (pend),
    .Overrun (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; f = 8'h00; rdy = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pend, valid, a, b, c, ovr} !== 13'd0) begin
      errors++;
      $display("FAIL reset_initial: got pend=%h valid=%b code=%b ovr=%b, want all zero",
               pend, valid, {a, b, c}, ovr);
    end
    tick();
    rst_n = 1'b1; en = 1'b1; f = 8'hFF;
    tick();
    tick();
    f = 8'h00;
    checks++;
    if (pend !== 8'hFF || valid !== 1'b1 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: got pend=%h valid=%b ovr=%b, want FF 1 1", pend, valid, ovr);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pend, valid, a, b, c, ovr} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async: got pend=%h valid=%b code=%b ovr=%b, want all zero",
               pend, valid, {a, b, c}, ovr);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] decoded;
    en = 1'b1; rdy = 1'b1; f = 8'b0100_0000;
    exp_q.push_back(3'b001);
    tick();
    f = 8'h00;
    checks++;
    if (valid !== 1'b0 || pend !== 8'h40) begin
      errors++;
      $display("FAIL single_capture: got valid=%b pend=%h, want 0 40", valid, pend);
    end
    tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: got valid=%b, want 1", valid);
    end
    decoded = 8'h01 << (3'd7 - {a, b, c});
    checks++;
    if (decoded !== 8'b0100_0000) begin
      errors++;
      $display("FAIL single_decode: got %b, want 01000000", decoded);
    end
    if (valid && rdy && exp_q.size() > 0) begin
      exp_code = exp_q.pop_front();
      checks++;
      if ({a, b, c} !== exp_code) begin
        errors++;
        $display("FAIL single_code: got %b, want %b", {a, b, c}, exp_code);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b0 || pend !== 8'h00 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_done: got valid=%b pend=%h left=%0d, want 0 00 0",
               valid, pend, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; rdy = 1'b1; f = 8'b0010_0101;
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b111);
    tick();
    f = 8'h00;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid%0d: got valid=%b, want 1", i, valid);
      end
      if (exp_q.size() > 0) begin
        exp_code = exp_q.pop_front();
        checks++;
        if ({a, b, c} !== exp_code) begin
          errors++;
          $display("FAIL b2b_code%0d: got %b, want %b", i, {a, b, c}, exp_code);
        end
      end
      tick();
    end
    checks++;
    if (valid !== 1'b0 || pend !== 8'h00 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got valid=%b pend=%h ovr=%b, want 0 00 0", valid, pend, ovr);
    end
  endtask

  task automatic test_stall();
    en = 1'b1; rdy = 1'b0; f = 8'b0000_0010;
    tick();
    f = 8'h00;
    tick();
    checks++;
    if (valid !== 1'b1 || {a, b, c} !== 3'b110) begin
      errors++;
      $display("FAIL stall_present: got valid=%b code=%b, want 1 110", valid, {a, b, c});
    end
    f = 8'b1000_0000;
    tick();
    f = 8'h00;
    tick();
    checks++;
    if (valid !== 1'b1 || {a, b, c} !== 3'b110 || pend !== 8'h82) begin
      errors++;
      $display("FAIL stall_nopreempt: got valid=%b code=%b pend=%h, want 1 110 82",
               valid, {a, b, c}, pend);
    end
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b000);
    rdy = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      if (valid && rdy) begin
        exp_code = exp_q.pop_front();
        checks++;
        if ({a, b, c} !== exp_code) begin
          errors++;
          $display("FAIL stall_drain: got %b, want %b", {a, b, c}, exp_code);
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got left=%0d valid=%b, want 0 0", exp_q.size(), valid);
      exp_q.delete();
    end
  endtask

  task automatic test_overrun();
    en = 1'b1; rdy = 1'b0; f = 8'b0000_1000;
    tick();
    f = 8'h00;
    tick();
    f = 8'b0000_1000;
    tick();
    f = 8'h00;
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, want 1", ovr);
    end
    tick();
    checks++;
    if (ovr !== 1'b1 || valid !== 1'b1 || {a, b, c} !== 3'b100) begin
      errors++;
      $display("FAIL overrun_sticky: got ovr=%b valid=%b code=%b, want 1 1 100",
               ovr, valid, {a, b, c});
    end
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    rdy = 1'b1; f = 8'b0000_1000;
    if (valid && rdy) begin
      exp_code = exp_q.pop_front();
      checks++;
      if ({a, b, c} !== exp_code) begin
        errors++;
        $display("FAIL setwins_first: got %b, want %b", {a, b, c}, exp_code);
      end
    end
    tick();
    f = 8'h00; rdy = 1'b0;
    checks++;
    if (pend !== 8'h08 || valid !== 1'b0) begin
      errors++;
      $display("FAIL setwins_pending: got pend=%h valid=%b, want 08 0", pend, valid);
    end
    tick();
    rdy = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      if (valid && rdy) begin
        exp_code = exp_q.pop_front();
        checks++;
        if ({a, b, c} !== exp_code) begin
          errors++;
          $display("FAIL setwins_again: got %b, want %b", {a, b, c}, exp_code);
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || valid !== 1'b0 || pend !== 8'h00 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_end: got left=%0d valid=%b pend=%h ovr=%b, want 0 0 00 1",
               exp_q.size(), valid, pend, ovr);
      exp_q.delete();
    end
  endtask

  task automatic test_enable();
    en = 1'b0; rdy = 1'b0; f = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pend !== 8'h00 || valid !== 1'b0) begin
        errors++;
        $display("FAIL enable_block%0d: got pend=%h valid=%b, want 00 0", i, pend, valid);
      end
    end
    en = 1'b1; f = 8'b0011_0000;
    tick();
    en = 1'b0; f = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pend !== 8'h30 || valid !== 1'b1 || {a, b, c} !== 3'b010) begin
        errors++;
        $display("FAIL enable_hold%0d: got pend=%h valid=%b code=%b, want 30 1 010",
                 i, pend, valid, {a, b, c});
      end
    end
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b011);
    rdy = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      if (valid && rdy) begin
        exp_code = exp_q.pop_front();
        checks++;
        if ({a, b, c} !== exp_code) begin
          errors++;
          $display("FAIL enable_drain: got %b, want %b", {a, b, c}, exp_code);
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || valid !== 1'b0 || pend !== 8'h00) begin
      errors++;
      $display("FAIL enable_end: got left=%0d valid=%b pend=%h, want 0 0 00",
               exp_q.size(), valid, pend);
      exp_q.delete();
    end
    en = 1'b1; f = 8'h00; rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
